// File: rtl/wshb_sdram_arbiter_pkg.sv
// Shared types for the two-master Wishbone SDRAM arbiter.
// Optional burst limit is enabled with the WSHB_ARB_BURST_LIMIT_EN macro (see top).
package wshb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

   localparam int N_REQ = 2;

endpackage

// File: rtl/wshb_sdram_arbiter_if.sv
// Classic Wishbone bus bundle shared by the two requesters and the SDRAM slave port.
// The master modport drives the request side; the slave modport drives the response side.
interface wshb_if
   import wshb_arb_pkg::*;
#(
   parameter int DATA_BYTES = 4,
   parameter int ADR_W      = 32
);
   logic                    cyc;
   logic                    stb;
   logic                    we;
   logic [ADR_W-1:0]        adr;
   logic [8*DATA_BYTES-1:0] dat_ms;
   logic [8*DATA_BYTES-1:0] dat_sm;
   logic [DATA_BYTES-1:0]   sel;
   logic [2:0]              cti;
   logic [1:0]              bte;
   logic                    ack;
   logic                    err;
   logic                    rty;

   modport master (
      output cyc, stb, we, adr, dat_ms, sel, cti, bte,
      input  dat_sm, ack, err, rty
   );

   modport slave (
      input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
      output dat_sm, ack, err, rty
   );
endinterface

// File: rtl/wshb_sdram_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: on a tie the port that did not win last goes next.
module rr_pick2
   import wshb_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic             last_gnt,
   output logic             pick_valid,
   output logic             pick_idx
);

   assign pick_valid = |req;
   assign pick_idx   = (&req) ? ~last_gnt : req[1];

endmodule

// File: rtl/wshb_sdram_arbiter.sv
// Two-master round-robin arbiter in front of the SDRAM Wishbone slave; grant held per cycle.
// Define WSHB_ARB_BURST_LIMIT_EN to force release after MAX_BURST responses when the other port waits.
module wshb_sdram_arbiter
   import wshb_arb_pkg::*;
#(
   parameter int DATA_BYTES = 4,
   parameter int MAX_BURST  = 64,
   parameter int ADR_W      = 32
)(
   input  logic        sys_clk,
   input  logic        sys_rst,
   wshb_if.slave       wshb_ifs0,
   wshb_if.slave       wshb_ifs1,
   wshb_if.master      wshb_ifm,
   output logic [1:0]  grant
);

   if (MAX_BURST < 1) begin : g_bad_max_burst
      $error("MAX_BURST must be at least 1");
   end

   arb_state_t state_q, state_d;
   logic       last_gnt_q, last_gnt_d;
   logic       pick_valid, pick_idx;
   logic       limit_hit;

   rr_pick2 u_pick (
      .req        ({wshb_ifs1.cyc, wshb_ifs0.cyc}),
      .last_gnt   (last_gnt_q),
      .pick_valid (pick_valid),
      .pick_idx   (pick_idx)
   );

`ifdef WSHB_ARB_BURST_LIMIT_EN
   localparam int                 CNT_W    = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MAX_BURST - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             slv_resp;
   logic             other_cyc;

   assign slv_resp  = wshb_ifm.ack | wshb_ifm.err | wshb_ifm.rty;
   assign other_cyc = (state_q == GNT0) ? wshb_ifs1.cyc : wshb_ifs0.cyc;
   // Pre-empt only on the response edge that completes the MAX_BURST-th transfer.
   assign limit_hit = (state_q != IDLE) && slv_resp && other_cyc && (cnt_q >= CNT_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE) begin
         cnt_d = '0;
      end else if (slv_resp && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign limit_hit = 1'b0;
`endif

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
      end
   end

   // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               state_d    = pick_idx ? GNT1 : GNT0;
               last_gnt_d = pick_idx;
            end
         end
         GNT0:    if (!wshb_ifs0.cyc || limit_hit) state_d = IDLE;
         GNT1:    if (!wshb_ifs1.cyc || limit_hit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   logic                    mux_cyc, mux_stb, mux_we;
   logic [ADR_W-1:0]        mux_adr;
   logic [8*DATA_BYTES-1:0] mux_dat;
   logic [DATA_BYTES-1:0]   mux_sel;
   logic [2:0]              mux_cti;
   logic [1:0]              mux_bte;

   always_comb begin
      mux_cyc = 1'b0;
      mux_stb = 1'b0;
      mux_we  = 1'b0;
      mux_adr = '0;
      mux_dat = '0;
      mux_sel = '0;
      mux_cti = '0;
      mux_bte = '0;
      case (state_q)
         GNT0: begin
            mux_cyc = wshb_ifs0.cyc;
            mux_stb = wshb_ifs0.stb;
            mux_we  = wshb_ifs0.we;
            mux_adr = wshb_ifs0.adr;
            mux_dat = wshb_ifs0.dat_ms;
            mux_sel = wshb_ifs0.sel;
            mux_cti = wshb_ifs0.cti;
            mux_bte = wshb_ifs0.bte;
         end
         GNT1: begin
            mux_cyc = wshb_ifs1.cyc;
            mux_stb = wshb_ifs1.stb;
            mux_we  = wshb_ifs1.we;
            mux_adr = wshb_ifs1.adr;
            mux_dat = wshb_ifs1.dat_ms;
            mux_sel = wshb_ifs1.sel;
            mux_cti = wshb_ifs1.cti;
            mux_bte = wshb_ifs1.bte;
         end
         default: ;
      endcase
   end

   assign wshb_ifm.cyc    = mux_cyc;
   assign wshb_ifm.stb    = mux_stb;
   assign wshb_ifm.we     = mux_we;
   assign wshb_ifm.adr    = mux_adr;
   assign wshb_ifm.dat_ms = mux_dat;
   assign wshb_ifm.sel    = mux_sel;
   assign wshb_ifm.cti    = mux_cti;
   assign wshb_ifm.bte    = mux_bte;

   assign grant = {state_q == GNT1, state_q == GNT0};

   assign wshb_ifs0.ack    = wshb_ifm.ack & grant[0];
   assign wshb_ifs0.err    = wshb_ifm.err & grant[0];
   assign wshb_ifs0.rty    = wshb_ifm.rty & grant[0];
   assign wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
   assign wshb_ifs1.ack    = wshb_ifm.ack & grant[1];
   assign wshb_ifs1.err    = wshb_ifm.err & grant[1];
   assign wshb_ifs1.rty    = wshb_ifm.rty & grant[1];
   assign wshb_ifs1.dat_sm = wshb_ifm.dat_sm;

endmodule

// File: tb/tb_wshb_sdram_arbiter.sv
// Self-checking bench for wshb_sdram_arbiter: directed scenarios plus randomized traffic
// compared each cycle against an owner/last-winner model; honours WSHB_ARB_BURST_LIMIT_EN.
module tb_wshb_sdram_arbiter;

`ifdef WSHB_ARB_BURST_LIMIT_EN
   localparam int MAXB     = 4;
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam int MAXB     = 64;
   localparam bit LIMIT_EN = 1'b0;
`endif
   localparam int DB = 4;
   localparam int AW = 32;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic [1:0] grant;

   wshb_if #(.DATA_BYTES(DB), .ADR_W(AW)) m0_if ();
   wshb_if #(.DATA_BYTES(DB), .ADR_W(AW)) m1_if ();
   wshb_if #(.DATA_BYTES(DB), .ADR_W(AW)) s_if ();

   wshb_sdram_arbiter #(.DATA_BYTES(DB), .MAX_BURST(MAXB), .ADR_W(AW)) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .wshb_ifs0 (m0_if),
      .wshb_ifs1 (m1_if),
      .wshb_ifm  (s_if),
      .grant     (grant)
   );

   always #5 sys_clk = ~sys_clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         if (n_bad <= 40)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: who owns the bus, who won last ----------------
   int   m_owner = -1;  // -1 = nobody, else port number
   int   m_last  = 1;
   int   m_acks  = 0;
   logic own_cyc, oth_cyc, s_resp;

   assign own_cyc = (m_owner == 1) ? m1_if.cyc : m0_if.cyc;
   assign oth_cyc = (m_owner == 1) ? m0_if.cyc : m1_if.cyc;
   assign s_resp  = s_if.ack | s_if.err | s_if.rty;

   always @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         m_owner <= -1;
         m_last  <= 1;
         m_acks  <= 0;
      end else if (m_owner < 0) begin
         if (m0_if.cyc && m1_if.cyc) begin
            m_owner <= 1 - m_last;
            m_last  <= 1 - m_last;
            m_acks  <= 0;
         end else if (m0_if.cyc) begin
            m_owner <= 0;
            m_last  <= 0;
            m_acks  <= 0;
         end else if (m1_if.cyc) begin
            m_owner <= 1;
            m_last  <= 1;
            m_acks  <= 0;
         end
      end else begin
         if (!own_cyc)
            m_owner <= -1;
         else if (LIMIT_EN && s_resp && (m_acks + 1 >= MAXB) && oth_cyc)
            m_owner <= -1;
         if (s_resp) m_acks <= m_acks + 1;
      end
   end

   task automatic compare_outputs();
      logic [11:0]     e_ctl;
      logic [AW-1:0]   e_adr;
      logic [8*DB-1:0] e_dat;
      logic [2:0]      e_r0, e_r1, rsp;
      logic [1:0]      e_gnt;
      rsp   = {s_if.ack, s_if.err, s_if.rty};
      e_ctl = '0;
      e_adr = '0;
      e_dat = '0;
      e_r0  = '0;
      e_r1  = '0;
      e_gnt = '0;
      if (m_owner == 0) begin
         e_ctl = {m0_if.cyc, m0_if.stb, m0_if.we, m0_if.sel, m0_if.cti, m0_if.bte};
         e_adr = m0_if.adr;
         e_dat = m0_if.dat_ms;
         e_r0  = rsp;
         e_gnt = 2'b01;
      end else if (m_owner == 1) begin
         e_ctl = {m1_if.cyc, m1_if.stb, m1_if.we, m1_if.sel, m1_if.cti, m1_if.bte};
         e_adr = m1_if.adr;
         e_dat = m1_if.dat_ms;
         e_r1  = rsp;
         e_gnt = 2'b10;
      end
      check("slave_ctl", {s_if.cyc, s_if.stb, s_if.we, s_if.sel, s_if.cti, s_if.bte}, e_ctl);
      check("slave_adr", s_if.adr, e_adr);
      check("slave_dat", s_if.dat_ms, e_dat);
      check("p0_resp", {m0_if.ack, m0_if.err, m0_if.rty}, e_r0);
      check("p1_resp", {m1_if.ack, m1_if.err, m1_if.rty}, e_r1);
      check("p0_dat_sm", m0_if.dat_sm, s_if.dat_sm);
      check("p1_dat_sm", m1_if.dat_sm, s_if.dat_sm);
      check("grant", grant, e_gnt);
   endtask

   always @(negedge sys_clk) if (chk_on) compare_outputs();

   // ---------------- stimulus helpers ----------------
   task automatic drive_m(input int p, input logic cyc, input logic stb);
      if (p == 0) begin
         m0_if.cyc = cyc;
         m0_if.stb = stb;
      end else begin
         m1_if.cyc = cyc;
         m1_if.stb = stb;
      end
   endtask

   task automatic rand_fields();
      m0_if.we     = 1'($urandom);
      m0_if.adr    = $urandom;
      m0_if.dat_ms = $urandom;
      m0_if.sel    = 4'($urandom);
      m0_if.cti    = 3'($urandom);
      m0_if.bte    = 2'($urandom);
      m1_if.we     = 1'($urandom);
      m1_if.adr    = $urandom;
      m1_if.dat_ms = $urandom;
      m1_if.sel    = 4'($urandom);
      m1_if.cti    = 3'($urandom);
      m1_if.bte    = 2'($urandom);
      s_if.dat_sm  = $urandom;
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic reset_pulse();
      #1 sys_rst = 1'b1;
      #1 sys_rst = 1'b0;
   endtask

   task automatic release_all();
      drive_m(0, 1'b0, 1'b0);
      drive_m(1, 1'b0, 1'b0);
      s_if.ack = 1'b0;
      s_if.err = 1'b0;
      s_if.rty = 1'b0;
      tick();
      tick();
   endtask

   int acc0, acc1;
   int hold[2];
   logic [1:0] alt_exp[11];

   initial begin
      drive_m(0, 1'b0, 1'b0);
      drive_m(1, 1'b0, 1'b0);
      s_if.ack = 1'b0;
      s_if.err = 1'b0;
      s_if.rty = 1'b0;
      rand_fields();
      chk_on = 1'b1;

      // 1: reset released with port 0 already requesting
      drive_m(0, 1'b1, 1'b1);
      m0_if.adr = 32'h1000_0040;
      repeat (3) @(posedge sys_clk);
      #2 sys_rst = 1'b0;
      tick();
      check("t1_grant", grant, 2'b01);
      check("t1_slave_adr", s_if.adr, 32'h1000_0040);
      acc0 = 0;
      acc1 = 0;
      s_if.ack = 1'b1;
      repeat (8) begin
         @(negedge sys_clk);
         acc0 += int'(m0_if.ack);
         acc1 += int'(m1_if.ack);
         tick();
      end
      s_if.ack = 1'b0;
      check("t1_acks_p0", acc0, 8);
      check("t1_acks_p1", acc1, 0);
      drive_m(0, 1'b0, 1'b0);
      tick();
      check("t1_release", grant, 2'b00);

      // 2: simultaneous requests after reset, port 0 first, then one idle cycle
      reset_pulse();
      drive_m(0, 1'b1, 1'b1);
      drive_m(1, 1'b1, 1'b1);
      tick();
      check("t2_first", grant, 2'b01);
      repeat (3) tick();
      drive_m(0, 1'b0, 1'b0);
      tick();
      check("t2_gap_grant", grant, 2'b00);
      check("t2_gap_cyc", s_if.cyc, 1'b0);
      tick();
      check("t2_second", grant, 2'b10);
      release_all();

`ifndef WSHB_ARB_BURST_LIMIT_EN
      // 3: long port-1 cycle starves port 0 until cyc1 falls
      acc0 = 0;
      drive_m(1, 1'b1, 1'b1);
      for (int c = 0; c < 200; c++) begin
         if (c == 10) drive_m(0, 1'b1, 1'b1);
         s_if.ack = 1'($urandom);
         @(negedge sys_clk);
         acc0 += int'(m0_if.ack);
         tick();
      end
      check("t3_p0_acks", acc0, 0);
      check("t3_held", grant, 2'b10);
      drive_m(1, 1'b0, 1'b0);
      s_if.ack = 1'b0;
      tick();
      check("t3_gap", grant, 2'b00);
      tick();
      check("t3_switch", grant, 2'b01);
      release_all();
`else
      // 4: continuous requests alternate every MAX_BURST acks with a one-cycle gap
      alt_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
                  2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01};
      reset_pulse();
      drive_m(0, 1'b1, 1'b1);
      drive_m(1, 1'b1, 1'b1);
      s_if.ack = 1'b1;
      for (int k = 0; k < 11; k++) begin
         tick();
         check("t4_alternate", grant, alt_exp[k]);
      end
      release_all();
`endif

      // 5: asynchronous reset in the middle of a port-1 transfer
      drive_m(1, 1'b1, 1'b1);
      tick();
      tick();
      check("t5_gnt1", grant, 2'b10);
      #1 sys_rst = 1'b1;
      #1;
      check("t5_rst_cyc", s_if.cyc, 1'b0);
      check("t5_rst_stb", s_if.stb, 1'b0);
      check("t5_rst_grant", grant, 2'b00);
      drive_m(0, 1'b1, 1'b1);
      #1 sys_rst = 1'b0;
      tick();
      check("t5_after_rst", grant, 2'b01);
      release_all();

      // 6: err on port 1 goes to port 1 only and does not release the grant
      drive_m(1, 1'b1, 1'b1);
      tick();
      drive_m(0, 1'b1, 1'b1);
      s_if.err = 1'b1;
      #1;
      check("t6_p1_err", m1_if.err, 1'b1);
      check("t6_p0_err", m0_if.err, 1'b0);
      check("t6_p0_ack", m0_if.ack, 1'b0);
      tick();
      s_if.err = 1'b0;
      repeat (3) tick();
      check("t6_held", grant, 2'b10);
      drive_m(1, 1'b0, 1'b0);
      tick();
      check("t6_gap", grant, 2'b00);
      tick();
      check("t6_p0_next", grant, 2'b01);
      release_all();

      // randomized traffic, occasional async reset
      hold[0] = 0;
      hold[1] = 0;
      for (int c = 0; c < 4000; c++) begin
         tick();
         for (int p = 0; p < 2; p++) begin
            if (hold[p] > 0) hold[p]--;
            else if ($urandom_range(0, 3) == 0) hold[p] = $urandom_range(1, 40);
            drive_m(p, hold[p] > 0, (hold[p] > 0) && ($urandom_range(0, 3) != 0));
         end
         rand_fields();
         begin
            int   r;
            logic own_stb;
            r       = $urandom_range(0, 19);
            own_stb = (m_owner == 0) ? m0_if.stb : (m_owner == 1) ? m1_if.stb : 1'b0;
            s_if.ack = 1'b0;
            s_if.err = 1'b0;
            s_if.rty = 1'b0;
            if (own_stb) begin
               if (r < 10)       s_if.ack = 1'b1;
               else if (r == 10) s_if.err = 1'b1;
               else if (r == 11) s_if.rty = 1'b1;
            end else if (r == 0) begin
               s_if.ack = 1'b1;
            end
         end
         if ($urandom_range(0, 499) == 0) begin
            #1 sys_rst = 1'b1;
            #1 sys_rst = 1'b0;
         end
      end
      release_all();

      chk_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wshb_sdram_arbiter.md
Name: wshb_sdram_arbiter

Overview:
- Shares the single SDRAM Wishbone slave port (DATA_BYTES=4, sys_clk domain) between two Wishbone masters: port 0 (video stream reader) and port 1 (frame writer / pattern generator).
- Two-master round-robin arbiter. A grant is held for the whole Wishbone cycle (cyc high). A one-cycle bus gap separates grants.
- Sits between the masters and the hw_support SDRAM slave interface. It replaces the constant-zero tie-off of that interface.

Parameters:
- DATA_BYTES, 4, byte width of all three Wishbone interfaces (data = 8*DATA_BYTES bits, sel = DATA_BYTES bits).
- MAX_BURST, 64, number of acks after which a grant is forcibly released. Used only with WSHB_ARB_BURST_LIMIT_EN.

Ports:
- sys_clk, input, 1: system clock, 100 MHz.
- sys_rst, input, 1: asynchronous, active-high reset.
- wshb_ifs0, wshb_if.slave, -: requester 0 (video reader).
- wshb_ifs1, wshb_if.slave, -: requester 1 (writer).
- wshb_ifm, wshb_if.master, -: toward the SDRAM slave.
- grant, output, 2: one-hot current grant (bit i = port i owns the bus); 2'b00 when idle.

Interface note: reset sys_rst, asynchronous, active-high; clock sys_clk.

Behaviour:
- State register, values IDLE, GNT0, GNT1. Register last_gnt (1 bit). Reset: state=IDLE, last_gnt=1 (port 0 wins the first tie), burst counter=0.
- Outputs in IDLE:
  - wshb_ifm.cyc, stb, we = 0.
  - adr, dat_ms, sel, cti, bte = 0.
  - ack, err, rty to both requesters = 0.
  - dat_sm to both requesters = slave dat_sm (pass-through, always).
  - grant = 2'b00.
- Outputs in GNTi:
  - Port i's cyc/stb/we/adr/dat_ms/sel/cti/bte are routed combinationally to wshb_ifm.
  - Slave ack/err/rty are routed to port i only.
  - The other port sees ack/err/rty = 0, so it simply waits.
  - grant[i] = 1.
- Transitions out of IDLE (evaluated every edge):
  - Only cyc0 high -> GNT0.
  - Only cyc1 high -> GNT1.
  - Both high -> GNT of the port != last_gnt.
  - Neither -> stay IDLE.
  - On entering GNTi, last_gnt <= i.
- Transitions out of GNTi:
  - cyc_i low at the edge -> IDLE.
  - Otherwise stay.
- Latency and gap:
  - Request seen in IDLE at edge n -> slave cyc high from cycle n+1 (one cycle).
  - Release always passes through IDLE for exactly one cycle. Back-to-back requests from alternating masters therefore see a 1-cycle gap.
- Master protocol: a master must not drop cyc while stb is waiting for ack. If it does, the arbiter releases anyway and the slave sees cyc/stb fall; no ack is delivered.
- Same-cycle ack and cyc drop: the ack is still routed to the granted port that cycle; the state goes IDLE at the edge.
- err/rty are treated like ack for burst counting; they do not force release.
- Reset mid-transfer: state goes to IDLE immediately (asynchronous), slave cyc/stb drop in the same cycle, and last_gnt returns to 1.
- Routing is purely combinational from state; no registered datapath. The slave-to-master response path has zero added latency.

Optional Feature:
- Macro: WSHB_ARB_BURST_LIMIT_EN.
- With the macro defined:
  - A counter of $clog2(MAX_BURST+1) bits counts acks in GNTi and clears on entering GNTi.
  - When count reaches MAX_BURST at an ack edge and the other port's cyc is high, the state goes to IDLE even though cyc_i is still high.
  - last_gnt then makes the other port win at the next IDLE.
  - The pre-empted master stays waiting (no ack) and is re-granted later.
  - Release only happens on an ack edge, never with a transfer outstanding.
- Without the macro: no counter; a grant is held until cyc drops. A video burst can starve the writer indefinitely.

Decomposition:
- Package wshb_arb_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE, GNT0, GNT1}.
  - localparam int N_REQ = 2.
- Sub-module rr_pick2: combinational round-robin decision.
  - Inputs req[1:0], last_gnt.
  - Outputs pick_valid, pick_idx.
  - Reused by the future 3-port version.
- Top-level module holds the state/counter registers and the muxes.

Test Plan:
1. Reset release with cyc0=1, cyc1=0 -> grant=01 one cycle after the first edge; slave adr equals port-0 adr; 8 acks delivered to port 0 only.
2. cyc0 and cyc1 rise in the same cycle after reset -> port 0 granted first. After port 0 drops cyc: one IDLE cycle (slave cyc=0), then grant=10.
3. Port 1 holds cyc for 200 cycles while port 0 requests at cycle 10 (macro off) -> port 0 ack=0 throughout; grant switches to 01 one cycle after cyc1 falls.
4. Macro on, MAX_BURST=4, both requesting continuously -> grants alternate every 4 acks with a 1-cycle gap; no master ever receives an ack while not granted.
5. Assert sys_rst during a GNT1 transfer with stb high -> slave cyc/stb=0 and grant=00 in the same cycle. After release with both requesting -> port 0 granted.
6. Slave returns err on port 1's transfer -> err seen on port 1 only; grant held until cyc1 drops; port 0 sees no err/ack.
